counter_ctrl: RTL
=================

Name: counter_ctrl

Overview:
- Programmable timer controller wrapped around an 8-bit up-counter datapath.
- Sequences the count: start, pause/resume, stop, terminal-count detection, one-shot or auto-reload, clock-enable prescaling.
- Gives upstream logic (LED blinkers, segment scanners, delay generators) a single start/stop interface in place of a free-running counter.

Parameters:
- WIDTH, 8, count register and terminal value width
- PRESC_W, 8, prescaler width

Ports:
- clk, input, 1, system clock; all logic is rising-edge.
- rst, input, 1, synchronous reset, active-high.
- start, input, 1, level-sampled. Arms a run when the controller is in IDLE or DONE.
- stop, input, 1, level-sampled. Aborts to IDLE from any state.
- pause, input, 1, level. Holds the count while high.
- auto_reload, input, 1, mode select: 1 = periodic, 0 = one-shot. Latched at start.
- terminal, input, WIDTH, last count value. Latched at start.
- prescale, input, PRESC_W, step divider. A step occurs every prescale+1 unpaused RUN cycles. Latched at start.
- q, output, WIDTH, current count (registered).
- tick, output, 1, one-cycle pulse when a step occurs at q==terminal (registered).
- busy, output, 1, high in RUN or HOLD.
- done, output, 1, high in DONE.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state = IDLE; q = 0; tick = 0; busy = 0; done = 0
  - prescaler count = 0; shadow terminal/prescale/auto_reload = 0
- Reset mid-run gives the same values at the next edge. It overrides every other input.
- States:
  - IDLE (00): q holds 0.
  - RUN (01): counting.
  - HOLD (10): paused; q and prescaler frozen.
  - DONE (11): q holds terminal.
- Input priority per cycle: rst > stop > start > pause > step.
- stop (any state): next state IDLE, q = 0, prescaler = 0, tick = 0. If stop and start are high together, stop wins.
- start (IDLE or DONE only):
  - Latches terminal, prescale and auto_reload into shadow registers.
  - Sets q = 0 and prescaler = 0. Next state RUN.
  - start while in RUN or HOLD is ignored; the shadow registers are unchanged.
- RUN with pause=1: next state HOLD. No step that cycle; the prescaler does not advance.
- HOLD: while pause=1, stay in HOLD. When pause=0, return to RUN on the next edge. The prescaler resumes from its frozen value.
- RUN with pause=0:
  - step = (prescaler == shadow prescale).
  - No step: prescaler increments.
  - On step, prescaler returns to 0, and then:
    - q != shadow terminal: q = q + 1.
    - q == shadow terminal with auto_reload=1: q = 0, tick = 1, stay in RUN.
    - q == shadow terminal with auto_reload=0: q holds, tick = 1, next state DONE.
- tick is high for exactly one cycle, coincident with the new state/q; it is 0 at all other times.
- q never exceeds the shadow terminal.
  - terminal = 2^WIDTH-1: natural wrap to 0.
  - terminal = 0: with reload, a tick on every step and q stays 0; one-shot goes to DONE on the first step.
- Timing: if start is sampled at edge E0, then RUN and q=0 hold from E0. Steps occur at E0+k*(prescale+1) for k≥1. The reload period is (terminal+1)*(prescale+1) cycles.
- Changes to terminal, prescale or auto_reload while busy have no effect until the next start.
- busy and done are decoded from the registered state (no extra latency).

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 → q=0, state IDLE, busy=0, done=0, tick=0; start is ignored while rst=1.
- One-shot: terminal=3, prescale=0, auto_reload=0, 1-cycle start → q steps 0,1,2,3 on successive cycles. tick is high one cycle as the state becomes DONE (4 cycles after the start edge). q stays 3, done=1.
- Periodic with prescale: terminal=2, prescale=1, auto_reload=1 → q changes every 2 cycles (0,1,2,0,...). tick every 6 cycles, exactly 1 cycle wide. busy stays 1.
- Pause: terminal=9, prescale=0; raise pause for 5 cycles at q=4 → state HOLD, q=4 frozen for those cycles. After release q resumes 5,6,... and the total steps to tick are unchanged.
- Stop/start collision: during RUN at q=7, assert stop and start together → next cycle IDLE, q=0, busy=0, no tick. A later start alone re-arms.
- Boundaries:
  - terminal=255, prescale=0, reload → q reaches 255, then 0 with tick; period 256 cycles.
  - terminal=0, reload → tick every cycle.
  - Changing terminal mid-run has no effect.
  - start in DONE re-arms from q=0.

Source files
------------

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - programmable timer controller around an up-counter
// Start/stop/pause sequencing, prescaled stepping, one-shot or auto-reload terminal count.
module counter_ctrl #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               auto_reload,
  input  logic [WIDTH-1:0]   terminal,
  input  logic [PRESC_W-1:0] prescale,
  output logic [WIDTH-1:0]   q,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   q_n;
  logic               tick_n;
  logic [PRESC_W-1:0] pcnt, pcnt_n;
  logic [WIDTH-1:0]   sh_term, sh_term_n;
  logic [PRESC_W-1:0] sh_presc, sh_presc_n;
  logic               sh_reload, sh_reload_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      q         <= '0;
      tick      <= 1'b0;
      pcnt      <= '0;
      sh_term   <= '0;
      sh_presc  <= '0;
      sh_reload <= 1'b0;
    end else begin
      state     <= state_n;
      q         <= q_n;
      tick      <= tick_n;
      pcnt      <= pcnt_n;
      sh_term   <= sh_term_n;
      sh_presc  <= sh_presc_n;
      sh_reload <= sh_reload_n;
    end
  end

  // Priority: stop > start (IDLE/DONE only) > pause > step.
  always_comb begin
    state_n     = state;
    q_n         = q;
    tick_n      = 1'b0;
    pcnt_n      = pcnt;
    sh_term_n   = sh_term;
    sh_presc_n  = sh_presc;
    sh_reload_n = sh_reload;
    if (stop) begin
      state_n = IDLE;
      q_n     = '0;
      pcnt_n  = '0;
    end else if (start && (state == IDLE || state == DONE)) begin
      state_n     = RUN;
      q_n         = '0;
      pcnt_n      = '0;
      sh_term_n   = terminal;
      sh_presc_n  = prescale;
      sh_reload_n = auto_reload;
    end else begin
      case (state)
        IDLE: q_n = '0;
        RUN: begin
          if (pause) begin
            state_n = HOLD;
          end else if (pcnt == sh_presc) begin
            pcnt_n = '0;
            if (q != sh_term) begin
              q_n = q + 1'b1;
            end else if (sh_reload) begin
              q_n    = '0;
              tick_n = 1'b1;
            end else begin
              tick_n  = 1'b1;
              state_n = DONE;
            end
          end else begin
            pcnt_n = pcnt + 1'b1;
          end
        end
        HOLD: if (!pause) state_n = RUN;
        DONE: q_n = sh_term;
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == HOLD);
  assign done = (state == DONE);

endmodule
